// File: rtl/pzvbus_credit_buffer_pkg.sv
// Shared sizing helpers for the pzvbus credit buffer and its storage array.
package pzvbus_credit_buffer_pkg;

  function automatic int calc_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A depth of 2 or less still needs one pointer bit.
  function automatic int calc_pointer_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pzvbus_credit_buffer_storage.sv
// DEPTH x WIDTH register array with one write port and a read-address mux.
module pzvbus_credit_buffer_storage
  import pzvbus_credit_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = calc_pointer_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (i_we && (i_waddr == PTR_W'(i))) mem_d[i] = i_wdata;
    end
  end

  // Payload storage has no reset; occupancy in the top decides what is valid.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_raddr == PTR_W'(i)) o_rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/pzvbus_credit_buffer.sv
// Credit-flow-controlled receive FIFO for a valid-only pzvbus link.
// Optional sticky overflow detection: PZVBUS_CREDIT_BUFFER_OVERFLOW_CHECK_EN.
module pzvbus_credit_buffer
  import pzvbus_credit_buffer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 4,
  parameter int CREDIT_LATENCY = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_payload,
  output logic                       o_credit_return,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_payload,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  localparam int PTR_W = calc_pointer_width(DEPTH);
  localparam int CNT_W = calc_count_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, pop, push;

  // A push while full is only taken when the same edge frees the head entry.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    pop      = !empty && i_ready;
    push     = i_valid && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  pzvbus_credit_buffer_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_payload),
    .i_raddr (rd_ptr_q),
    .o_rdata (o_payload)
  );

  assign o_valid = !empty;
  assign o_empty = empty;
  assign o_full  = full;
  assign o_count = count_q;

  // One shift stage per cycle of latency keeps every pop as its own pulse.
  if (CREDIT_LATENCY == 0) begin : g_credit_comb
    assign o_credit_return = pop;
  end else begin : g_credit_pipe
    logic [CREDIT_LATENCY-1:0] credit_q, credit_d;

    always_comb begin
      credit_d[0] = pop;
      for (int i = 1; i < CREDIT_LATENCY; i++) credit_d[i] = credit_q[i-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) credit_q <= '0;
      else          credit_q <= credit_d;
    end

    assign o_credit_return = credit_q[CREDIT_LATENCY-1];
  end

`ifdef PZVBUS_CREDIT_BUFFER_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q || (i_valid && full && !pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pzvbus_credit_buffer.sv
// Scoreboard bench for pzvbus_credit_buffer (DEPTH=3, CREDIT_LATENCY=2).
module tb_pzvbus_credit_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic [WIDTH-1:0] i_payload;
  logic             i_ready;
  logic             o_credit_return;
  logic             o_valid;
  logic [WIDTH-1:0] o_payload;
  logic             o_empty;
  logic             o_full;
  logic [CW-1:0]    o_count;
  logic             o_overflow;

  pzvbus_credit_buffer #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .CREDIT_LATENCY (LAT)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (i_valid),
    .i_payload       (i_payload),
    .o_credit_return (o_credit_return),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_payload       (o_payload),
    .o_empty         (o_empty),
    .o_full          (o_full),
    .o_count         (o_count),
    .o_overflow      (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy count, expected output order, pop history.
  int               m_cnt;
  bit               m_ovf;
  bit               pop_hist [LAT+1];
  logic [WIDTH-1:0] sb [$];
  int               exp_cnt;
  bit               exp_ovf;
  bit               exp_credit;
  bit               chk_en;
  bit               data_chk_en;
  bit               undef_zone;
  int               ret_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_ovf = 1'b0;
    for (int i = 0; i <= LAT; i++) pop_hist[i] = 1'b0;
    sb.delete();
    exp_cnt = 0;
    exp_ovf = 1'b0;
    exp_credit = 1'b0;
    data_chk_en = 1'b1;
    undef_zone = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_credit_return", o_credit_return, 0);
    chk("rst_o_empty", o_empty, 1);
    chk("rst_o_full", o_full, 0);
    chk("rst_o_count", o_count, 0);
    chk("rst_o_overflow", o_overflow, 0);
  endtask

  // Drive one cycle of stimulus and advance the model across the next edge.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] p, input bit r);
    bit pop, push;
    i_valid   = v;
    i_payload = p;
    i_ready   = r;
    exp_cnt   = m_cnt;
    exp_ovf   = m_ovf;
    pop  = r && (m_cnt > 0);
    push = v && ((m_cnt < DEPTH) || pop);
    for (int i = LAT; i > 0; i--) pop_hist[i] = pop_hist[i-1];
    pop_hist[0] = pop;
    exp_credit  = pop_hist[LAT];
    if (v && !push) begin
`ifdef PZVBUS_CREDIT_BUFFER_OVERFLOW_CHECK_EN
      m_ovf = 1'b1;
`else
      undef_zone = 1'b1;
`endif
    end
    if (push) sb.push_back(p);
    m_cnt = m_cnt + int'(push) - int'(pop);
    @(posedge clk);
    #1;
    if (undef_zone) data_chk_en = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the model once per cycle.
  initial begin : monitor
    logic [WIDTH-1:0] exp_pl;
    forever begin
      @(negedge clk);
      if (rst_n && o_credit_return) ret_cnt++;
      if (chk_en) begin
        chk("o_overflow", o_overflow, exp_ovf);
        if (data_chk_en) begin
          chk("o_count", o_count, exp_cnt);
          chk("o_valid", o_valid, exp_cnt != 0);
          chk("o_empty", o_empty, exp_cnt == 0);
          chk("o_full", o_full, exp_cnt == DEPTH);
          chk("o_credit_return", o_credit_return, exp_credit);
          if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
              chk("unexpected_pop", 1, 0);
            end else begin
              exp_pl = sb.pop_front();
              chk("o_payload", o_payload, exp_pl);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int sent;
    int ret_base;
    int credits;
    bit v;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_payload = '0;
    i_ready = 1'b0;
    chk_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Fill with ready low, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(32'hA0 + i), 1'b0);
    chk("fill_full", o_full, 1);
    chk("fill_count", o_count, DEPTH);
    for (int i = 0; i < DEPTH + LAT + 1; i++) cycle(1'b0, '0, 1'b1);
    chk("drain_empty", o_empty, 1);

    // Streaming: push and pop every cycle.
    for (int i = 0; i < 20; i++) cycle(1'b1, WIDTH'(i), 1'b1);
    for (int i = 0; i < LAT + 2; i++) cycle(1'b0, '0, 1'b1);

    // Push into a full FIFO together with a pop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(32'hB0 + i), 1'b0);
    cycle(1'b1, WIDTH'(32'hB4), 1'b1);
    chk("full_pushpop_count", o_count, DEPTH);
    for (int i = 0; i < DEPTH + LAT + 2; i++) cycle(1'b0, '0, 1'b1);

    // Random traffic from a credit-respecting sender.
    sent = 0;
    ret_base = ret_cnt;
    for (int n = 0; n < 400; n++) begin
      credits = DEPTH - sent + (ret_cnt - ret_base);
      v = (credits > 0) && ($urandom_range(0, 3) != 0);
      if (v) sent++;
      cycle(v, WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + LAT + 3; i++) cycle(1'b0, '0, 1'b1);
    chk("credits_restored", DEPTH - sent + (ret_cnt - ret_base), DEPTH);
    chk("random_sb_drained", sb.size(), 0);

    // Asynchronous reset with two entries held and a credit pulse in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(32'hC0 + i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    i_ready = 1'b0;
    #1;
    chk_reset_values();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < LAT + 3; i++) cycle(1'b0, '0, 1'b0);

    // Overflow: push while full with no pop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(32'hD0 + i), 1'b0);
    cycle(1'b1, WIDTH'(32'hDEAD), 1'b0);
    cycle(1'b0, '0, 1'b0);
`ifdef PZVBUS_CREDIT_BUFFER_OVERFLOW_CHECK_EN
    chk("overflow_set", o_overflow, 1);
`else
    chk("overflow_tied", o_overflow, 0);
`endif
    for (int i = 0; i < DEPTH + LAT + 2; i++) cycle(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
